// File: rtl/pwm_bridge_driver_pkg.sv
// Shared definitions for the PWM H-bridge driver: leg state encodings,
// direction constants, minimum carrier period and the reference magnitude helper.
package pwm_bridge_driver_pkg;

    typedef enum logic [1:0] {
        LEG_OFF  = 2'd0,
        LEG_HIGH = 2'd1,
        LEG_LOW  = 2'd2,
        LEG_DEAD = 2'd3
    } leg_state_t;

    localparam logic DIR_FWD    = 1'b0;
    localparam logic DIR_REV    = 1'b1;
    localparam int   MIN_PERIOD = 2;

    // Two's-complement magnitude; -32768 maps to 32768 as an unsigned value.
    function automatic logic [15:0] ref_magnitude(input logic signed [15:0] r);
        logic [15:0] raw;
        raw = $unsigned(r);
        return r[15] ? (~raw + 16'd1) : raw;
    endfunction

endpackage

// File: rtl/pwm_bridge_driver_dead_time_leg.sv
// One half-bridge leg: turns a high/low demand into exclusive hi/lo gate drives,
// with an all-off dead interval of dead_time clocks on every side change.
module dead_time_leg
    import pwm_bridge_driver_pkg::*;
#(
    parameter int DT_W = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            enable,
    input  logic            demand,
    input  logic [DT_W-1:0] dead_time,
    output logic            hi,
    output logic            lo
);

    leg_state_t      state, state_next;
    logic [DT_W-1:0] dead_cnt, dead_cnt_next;
    logic            side, side_next;
    logic            switch_req;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= LEG_OFF;
            dead_cnt <= '0;
            side     <= 1'b0;
            hi       <= 1'b0;
            lo       <= 1'b0;
        end else begin
            state    <= state_next;
            dead_cnt <= dead_cnt_next;
            side     <= side_next;
            hi       <= (state_next == LEG_HIGH);
            lo       <= (state_next == LEG_LOW);
        end
    end

    // dead_cnt holds the number of the current dead cycle; a zero dead time skips DEAD.
    always_comb begin
        state_next    = state;
        dead_cnt_next = dead_cnt;
        side_next     = side;
        switch_req    = 1'b0;
        if (!enable) begin
            state_next    = LEG_OFF;
            dead_cnt_next = '0;
        end else begin
            case (state)
                LEG_OFF:  switch_req = 1'b1;
                LEG_HIGH: switch_req = !demand;
                LEG_LOW:  switch_req = demand;
                LEG_DEAD: begin
                    if (demand != side) begin
                        switch_req = 1'b1;
                    end else if (dead_cnt >= dead_time) begin
                        state_next = side ? LEG_HIGH : LEG_LOW;
                    end else begin
                        dead_cnt_next = dead_cnt + DT_W'(1);
                    end
                end
                default: state_next = LEG_OFF;
            endcase
            if (switch_req) begin
                side_next = demand;
                if (dead_time == '0) begin
                    state_next = demand ? LEG_HIGH : LEG_LOW;
                end else begin
                    state_next    = LEG_DEAD;
                    dead_cnt_next = DT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pwm_bridge_driver.sv
// Edge-aligned PWM carrier with wrap-synchronous duty/direction update feeding
// two dead-time legs that drive one full H-bridge.
module pwm_bridge_driver
    import pwm_bridge_driver_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int DT_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [15:0]  pwm_ref,
    input  logic                pwm_ref_valid,
    input  logic [CNT_W-1:0]    period,
    input  logic [DT_W-1:0]     dead_time,
    output logic                hi_a,
    output logic                lo_a,
    output logic                hi_b,
    output logic                lo_b,
    output logic                period_start,
    output logic [CNT_W-1:0]    duty_applied,
    output logic                dir_applied
);

    localparam int MAG_W = (CNT_W > 16) ? CNT_W : 16;

    logic               running;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   period_sh;
    logic signed [15:0] pending;
    logic signed [15:0] pending_eff;
    logic [CNT_W-1:0]   period_clamped;
    logic [MAG_W-1:0]   mag_ext;
    logic [MAG_W-1:0]   period_ext;
    logic [CNT_W-1:0]   duty_next;
    logic               load;
    logic               switching;
    logic               demand_a;
    logic               demand_b;
    logic               leg_en;

    // A strobe coinciding with the wrap still makes that wrap.
    assign pending_eff    = pwm_ref_valid ? pwm_ref : pending;
    assign period_clamped = (period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;
    assign mag_ext        = MAG_W'(ref_magnitude(pending_eff));
    assign period_ext     = MAG_W'(period_clamped);
    assign duty_next      = (mag_ext < period_ext) ? mag_ext[CNT_W-1:0] : period_clamped;
    assign load           = enable && (!running || (cnt >= period_sh - CNT_W'(1)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (pwm_ref_valid) begin
            pending <= pwm_ref;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            running      <= 1'b0;
            cnt          <= '0;
            period_sh    <= CNT_W'(MIN_PERIOD);
            duty_applied <= '0;
            dir_applied  <= DIR_FWD;
        end else if (!enable) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            running      <= 1'b1;
            cnt          <= '0;
            period_sh    <= period_clamped;
            duty_applied <= duty_next;
            dir_applied  <= pending_eff[15] ? DIR_REV : DIR_FWD;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign switching    = running && (cnt < duty_applied);
    assign demand_a     = (dir_applied == DIR_FWD) && switching;
    assign demand_b     = (dir_applied == DIR_REV) && switching;
    assign leg_en       = enable && running;
    assign period_start = running && (cnt == '0);

    dead_time_leg #(.DT_W(DT_W)) u_leg_a (
        .clock     (clock),
        .reset     (reset),
        .enable    (leg_en),
        .demand    (demand_a),
        .dead_time (dead_time),
        .hi        (hi_a),
        .lo        (lo_a)
    );

    dead_time_leg #(.DT_W(DT_W)) u_leg_b (
        .clock     (clock),
        .reset     (reset),
        .enable    (leg_en),
        .demand    (demand_b),
        .dead_time (dead_time),
        .hi        (hi_b),
        .lo        (lo_b)
    );

endmodule

// File: tb/tb_pwm_bridge_driver.sv
// Directed bench for pwm_bridge_driver: per-period gate statistics are compared
// against hand-derived values for the carrier/dead-time timing.
module tb_pwm_bridge_driver;

    logic               clock;
    logic               reset;
    logic               enable;
    logic signed [15:0] pwm_ref;
    logic               pwm_ref_valid;
    logic [15:0]        period;
    logic [7:0]         dead_time;
    logic               hi_a, lo_a, hi_b, lo_b;
    logic               period_start;
    logic [15:0]        duty_applied;
    logic               dir_applied;

    int checkCount = 0;
    int passCount  = 0;
    int overlapCount = 0;
    int crossHighCount = 0;

    typedef struct {
        int hiA; int loA; int hiB; int loB;
        int offA; int offB;
        int firstHiA; int firstHiB;
        int starts; int dirOnes;
    } meas_t;

    pwm_bridge_driver #(.CNT_W(16), .DT_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .pwm_ref       (pwm_ref),
        .pwm_ref_valid (pwm_ref_valid),
        .period        (period),
        .dead_time     (dead_time),
        .hi_a          (hi_a),
        .lo_a          (lo_a),
        .hi_b          (hi_b),
        .lo_b          (lo_b),
        .period_start  (period_start),
        .duty_applied  (duty_applied),
        .dir_applied   (dir_applied)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if ((hi_a === 1'b1 && lo_a === 1'b1) || (hi_b === 1'b1 && lo_b === 1'b1)) overlapCount++;
        if (hi_a === 1'b1 && hi_b === 1'b1) crossHighCount++;
    end

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic en, input logic [15:0] per, input logic [7:0] dt);
        enable    = en;
        period    = per;
        dead_time = dt;
    endtask

    task automatic strobeRef(input logic [15:0] value);
        pwm_ref       = value;
        pwm_ref_valid = 1'b1;
        @(negedge clock);
        pwm_ref_valid = 1'b0;
    endtask

    task automatic waitPeriodStart(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (period_start !== 1'b1 && n < budget);
        if (period_start !== 1'b1) checkOutput(tag, 0, 1);
    endtask

    task automatic measureWindow(input int len, input int strobeAt, input logic [15:0] strobeVal,
                                 output meas_t m);
        m = '{default: 0};
        m.firstHiA = -1;
        m.firstHiB = -1;
        for (int i = 0; i < len; i++) begin
            m.hiA += int'(hi_a);
            m.loA += int'(lo_a);
            m.hiB += int'(hi_b);
            m.loB += int'(lo_b);
            if (!hi_a && !lo_a) m.offA++;
            if (!hi_b && !lo_b) m.offB++;
            if (hi_a && m.firstHiA < 0) m.firstHiA = i;
            if (hi_b && m.firstHiB < 0) m.firstHiB = i;
            m.starts  += int'(period_start);
            m.dirOnes += int'(dir_applied);
            if (i == strobeAt) begin
                pwm_ref       = strobeVal;
                pwm_ref_valid = 1'b1;
            end else begin
                pwm_ref_valid = 1'b0;
            end
            @(negedge clock);
        end
        pwm_ref_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin
        meas_t m;
        reset = 1'b1;
        pwm_ref = '0;
        pwm_ref_valid = 1'b0;
        applyStimulus(1'b0, 16'd0, 8'd0);
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_gates", {hi_a, lo_a, hi_b, lo_b}, 0);
        checkOutput("reset_period_start", period_start, 0);
        checkOutput("reset_duty", duty_applied, 0);
        checkOutput("reset_dir", dir_applied, 0);
        reset = 1'b1;
        @(negedge clock);

        // Forward 40/100, dead time 5
        applyStimulus(1'b1, 16'd100, 8'd5);
        strobeRef(16'd40);
        checkOutput("first_start", period_start, 1);
        waitPeriodStart("fwd_wrap_timeout", 150);
        measureWindow(100, -1, 16'd0, m);
        checkOutput("fwd_hi_a_width", m.hiA, 40 - 5);
        checkOutput("fwd_hi_a_rise", m.firstHiA, 1 + 5);
        checkOutput("fwd_lo_a_low", 100 - m.loA, 40 + 5);
        checkOutput("fwd_hi_b", m.hiB, 0);
        checkOutput("fwd_lo_b", m.loB, 100);
        checkOutput("fwd_duty", duty_applied, 40);
        checkOutput("fwd_dir", dir_applied, 0);

        // Full-scale reverse saturates to the 200-count period
        applyStimulus(1'b1, 16'd200, 8'd5);
        strobeRef(16'h8000);
        checkOutput("rev_dir_hold", dir_applied, 0);
        waitPeriodStart("rev_wrap_timeout", 150);
        checkOutput("rev_dir", dir_applied, 1);
        checkOutput("rev_duty", duty_applied, 200);
        measureWindow(200, -1, 16'd0, m);
        checkOutput("rev_hi_b_rise", m.firstHiB, 6);
        checkOutput("rev_hi_b_first", m.hiB, 194);
        measureWindow(200, -1, 16'd0, m);
        checkOutput("rev_hi_b_full", m.hiB, 200);
        checkOutput("rev_lo_a_full", m.loA, 200);
        checkOutput("rev_hi_a", m.hiA, 0);

        // +60 then -60 mid-period, dead time 3
        applyStimulus(1'b1, 16'd100, 8'd3);
        strobeRef(16'd60);
        waitPeriodStart("sw_wrap1_timeout", 250);
        waitPeriodStart("sw_wrap2_timeout", 150);
        measureWindow(100, 30, 16'hFFC4, m);
        checkOutput("sw_dir_held", m.dirOnes, 0);
        checkOutput("sw_hi_a_width", m.hiA, 57);
        checkOutput("sw_off_a", m.offA, 6);
        checkOutput("sw_wrap_start", period_start, 1);
        checkOutput("sw_dir", dir_applied, 1);
        checkOutput("sw_duty", duty_applied, 60);
        measureWindow(100, -1, 16'd0, m);
        checkOutput("sw_hi_b_rise", m.firstHiB, 4);
        checkOutput("sw_off_b", m.offB, 6);
        checkOutput("sw_hi_b_width", m.hiB, 57);
        checkOutput("sw_lo_a", m.loA, 100);

        // Drop enable at cnt 17, then re-enable
        applyStimulus(1'b1, 16'd100, 8'd5);
        strobeRef(16'd40);
        waitPeriodStart("en_wrap1_timeout", 150);
        waitPeriodStart("en_wrap2_timeout", 150);
        repeat (17) @(negedge clock);
        checkOutput("en_hi_a_before", hi_a, 1);
        enable = 1'b0;
        @(negedge clock);
        checkOutput("dis_gates", {hi_a, lo_a, hi_b, lo_b}, 0);
        checkOutput("dis_period_start", period_start, 0);
        repeat (3) @(negedge clock);
        checkOutput("dis_hold", {period_start, hi_a, lo_a, hi_b, lo_b}, 0);
        enable = 1'b1;
        @(negedge clock);
        checkOutput("reen_start", period_start, 1);
        measureWindow(100, -1, 16'd0, m);
        checkOutput("reen_hi_a_rise", m.firstHiA, 6);
        checkOutput("reen_hi_a_width", m.hiA, 35);
        checkOutput("reen_off_a", m.offA, 11);
        checkOutput("reen_off_b", m.offB, 6);

        // Minimum period, zero dead time
        applyStimulus(1'b1, 16'd2, 8'd0);
        strobeRef(16'd1);
        waitPeriodStart("min_wrap1_timeout", 150);
        waitPeriodStart("min_wrap2_timeout", 10);
        measureWindow(10, -1, 16'd0, m);
        checkOutput("min_hi_a", m.hiA, 5);
        checkOutput("min_hi_a_rise", m.firstHiA, 1);
        checkOutput("min_starts", m.starts, 5);
        checkOutput("min_off_a", m.offA, 0);

        // Asynchronous reset while hi_a is on
        applyStimulus(1'b1, 16'd100, 8'd5);
        strobeRef(16'd40);
        waitPeriodStart("ar_wrap1_timeout", 150);
        waitPeriodStart("ar_wrap2_timeout", 150);
        repeat (10) @(negedge clock);
        checkOutput("ar_hi_a_before", hi_a, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("ar_gates", {hi_a, lo_a, hi_b, lo_b}, 0);
        checkOutput("ar_duty", duty_applied, 0);
        checkOutput("ar_dir_start", {dir_applied, period_start}, 0);

        checkOutput("hi_lo_exclusive", overlapCount, 0);
        checkOutput("no_cross_high", crossHighCount, 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
